// File: rtl/vending_machine_pn.sv
// Single-product vending controller: accumulates coin credit, pulses sell at PRICE,
// then returns the remainder (or a cancelled credit) as a serial stream of 1/2-unit coins.
module vending_machine_pn #(
  parameter int PRICE      = 3,
  parameter int COIN_A_VAL = 1,
  parameter int COIN_B_VAL = 2,
  parameter int COIN_C_VAL = 10,
  parameter int CREDIT_W   = 5,
  parameter int SALES_W    = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [1:0]         coin,
  input  logic               cancel,
  output logic               sell,
  output logic [1:0]         change,
  output logic               busy,
  output logic               coin_rej,
  output logic [SALES_W-1:0] sold_cnt
);

  localparam int SUM_W    = CREDIT_W + 1;
  localparam int MAX_AB   = (COIN_A_VAL > COIN_B_VAL) ? COIN_A_VAL : COIN_B_VAL;
  localparam int MAX_COIN = (MAX_AB > COIN_C_VAL) ? MAX_AB : COIN_C_VAL;
  localparam logic [SUM_W-1:0] PRICE_S = SUM_W'(PRICE);

  if (PRICE < 1 || PRICE > (1 << CREDIT_W) - 1 - COIN_C_VAL ||
      PRICE - 1 + MAX_COIN > (1 << CREDIT_W) - 1) begin : g_bad_config
    $error("vending_machine_pn: PRICE/CREDIT_W out of legal range");
  end

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_CHANGE  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic                 sell_q, sell_d;
  logic [1:0]           change_q, change_d;
  logic                 coin_rej_q, coin_rej_d;
  logic [SALES_W-1:0]   sold_cnt_q, sold_cnt_d;
  logic [SUM_W-1:0]     sum_s;
  logic [SUM_W-1:0]     rem_s;

  function automatic logic [SUM_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      2'b01:   coin_value = SUM_W'(COIN_A_VAL);
      2'b10:   coin_value = SUM_W'(COIN_B_VAL);
      2'b11:   coin_value = SUM_W'(COIN_C_VAL);
      default: coin_value = {SUM_W{1'b0}};
    endcase
  endfunction

  // Next-state, credit bookkeeping and registered-output decisions
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    sell_d     = 1'b0;
    change_d   = 2'b00;
    coin_rej_d = 1'b0;
    sold_cnt_d = sold_cnt_q;
    sum_s      = {1'b0, credit_q} + coin_value(coin);
    rem_s      = sum_s - PRICE_S;
    case (state_q)
      ST_COLLECT: begin
        if (cancel) begin
          credit_d = sum_s[CREDIT_W-1:0];
          if (sum_s != {SUM_W{1'b0}}) begin
            state_d = ST_CHANGE;
          end else begin
            state_d = ST_COLLECT;
          end
        end else if (sum_s >= PRICE_S) begin
          sell_d     = 1'b1;
          sold_cnt_d = sold_cnt_q + SALES_W'(1);
          credit_d   = rem_s[CREDIT_W-1:0];
          if (rem_s != {SUM_W{1'b0}}) begin
            state_d = ST_CHANGE;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          credit_d = sum_s[CREDIT_W-1:0];
        end
      end
      ST_CHANGE: begin
        coin_rej_d = (coin != 2'b00);
        if (credit_q >= CREDIT_W'(2)) begin
          change_d = 2'b10;
          credit_d = credit_q - CREDIT_W'(2);
        end else begin
          change_d = 2'b01;
          credit_d = credit_q - CREDIT_W'(1);
        end
        // Leave on the same edge that empties the credit so busy drops with the last coin
        if (credit_d == {CREDIT_W{1'b0}}) begin
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_CHANGE;
        end
      end
      default: begin
        state_d  = ST_COLLECT;
        credit_d = {CREDIT_W{1'b0}};
      end
    endcase
  end

  // State, credit and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_COLLECT;
      credit_q   <= {CREDIT_W{1'b0}};
      sell_q     <= 1'b0;
      change_q   <= 2'b00;
      coin_rej_q <= 1'b0;
      sold_cnt_q <= {SALES_W{1'b0}};
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      sell_q     <= sell_d;
      change_q   <= change_d;
      coin_rej_q <= coin_rej_d;
      sold_cnt_q <= sold_cnt_d;
    end
  end

  assign sell     = sell_q;
  assign change   = change_q;
  assign busy     = (state_q == ST_CHANGE);
  assign coin_rej = coin_rej_q;
  assign sold_cnt = sold_cnt_q;

endmodule

// File: tb/tb_vending_machine_pn.sv
// Self-checking bench for vending_machine_pn: a coin-queue reference model predicts
// sell/change/busy/coin_rej/sold_cnt every cycle for directed and random stimulus.
module tb_vending_machine_pn;

  localparam int PRICE = 3;

  logic       clk;
  logic       rstn;
  logic [1:0] coin;
  logic       cancel;
  logic       sell, busy, coin_rej;
  logic [1:0] change;
  logic [7:0] sold_cnt;
  logic       sell2, busy2, rej2;
  logic [1:0] change2;
  logic [1:0] sold2;

  int n_cmp;
  int n_err;

  // Reference model: pending change coins as a queue
  int         m_credit;
  int         m_q[$];
  int         m_sold;
  logic       e_sell, e_rej;
  logic [1:0] e_change;
  logic       e_busy;

  vending_machine_pn dut (
    .clk(clk), .rstn(rstn), .coin(coin), .cancel(cancel),
    .sell(sell), .change(change), .busy(busy), .coin_rej(coin_rej), .sold_cnt(sold_cnt)
  );

  vending_machine_pn #(.SALES_W(2)) dut_w2 (
    .clk(clk), .rstn(rstn), .coin(coin), .cancel(cancel),
    .sell(sell2), .change(change2), .busy(busy2), .coin_rej(rej2), .sold_cnt(sold2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int value_of(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 10;
      default: return 0;
    endcase
  endfunction

  task automatic push_refund(input int amount);
    for (int k = 0; k < amount / 2; k++) m_q.push_back(2);
    if (amount % 2 == 1) m_q.push_back(1);
  endtask

  task automatic model_reset();
    m_credit = 0;
    m_q.delete();
    m_sold   = 0;
    e_sell   = 1'b0;
    e_rej    = 1'b0;
    e_change = 2'b00;
    e_busy   = 1'b0;
  endtask

  task automatic model_update(input logic [1:0] c, input logic x);
    int sum;
    e_sell   = 1'b0;
    e_rej    = 1'b0;
    e_change = 2'b00;
    if (m_q.size() > 0) begin
      e_change = 2'(m_q.pop_front());
      e_rej    = (c != 2'b00);
    end else begin
      sum = m_credit + value_of(c);
      if (x) begin
        m_credit = 0;
        push_refund(sum);
      end else if (sum >= PRICE) begin
        e_sell   = 1'b1;
        m_sold   = m_sold + 1;
        m_credit = 0;
        push_refund(sum - PRICE);
      end else begin
        m_credit = sum;
      end
    end
    e_busy = (m_q.size() > 0);
  endtask

  task automatic step(input logic [1:0] c, input logic x);
    coin   = c;
    cancel = x;
    @(posedge clk);
    model_update(c, x);
    #1;
    coin   = 2'b00;
    cancel = 1'b0;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rstn = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; coin = 2'b00; cancel = 1'b0;
    model_reset();
    #12;
    n_cmp++;
    if ({sell, change, busy, coin_rej, sold_cnt, sold2} !== 15'd0) begin
      n_err++;
      $display("FAIL reset: got %b want all zero", {sell, change, busy, coin_rej, sold_cnt, sold2});
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_sequence(input string name, input logic [1:0] coins[$],
                               input logic cancels[$], input int idle);
    for (int i = 0; i < coins.size() + idle; i++) begin
      if (i < coins.size()) step(coins[i], cancels[i]);
      else step(2'b00, 1'b0);
      n_cmp++;
      if ({sell, change, busy, coin_rej, sold_cnt} !==
          {e_sell, e_change, e_busy, e_rej, 8'(m_sold)}) begin
        n_err++;
        $display("FAIL %s cyc%0d: got sell=%b chg=%b busy=%b rej=%b cnt=%0d want %b %b %b %b %0d",
                 name, i, sell, change, busy, coin_rej, sold_cnt,
                 e_sell, e_change, e_busy, e_rej, m_sold % 256);
      end
    end
  endtask

  task automatic test_directed();
    test_sequence("three_a", '{2'b01, 2'b01, 2'b01}, '{1'b0, 1'b0, 1'b0}, 3);
    test_sequence("two_b",   '{2'b10, 2'b10}, '{1'b0, 1'b0}, 3);
    test_sequence("coin_c",  '{2'b11}, '{1'b0}, 6);
    test_sequence("cancel",  '{2'b10, 2'b00}, '{1'b0, 1'b1}, 3);
    test_sequence("cancel_same", '{2'b01}, '{1'b1}, 3);
    test_sequence("cancel_empty", '{2'b00}, '{1'b1}, 2);
    test_sequence("reject",  '{2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01},
                  '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 2);
  endtask

  task automatic test_reset_mid_change();
    step(2'b11, 1'b0);
    step(2'b00, 1'b0);
    step(2'b00, 1'b0);
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({sell, change, busy, coin_rej, sold_cnt} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_mid: got %b want all zero", {sell, change, busy, coin_rej, sold_cnt});
    end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    test_sequence("after_reset", '{2'b00, 2'b00, 2'b10, 2'b01},
                  '{1'b0, 1'b0, 1'b0, 1'b0}, 2);
  endtask

  task automatic test_wrap();
    hard_reset();
    for (int s = 0; s < 5; s++) begin
      step(2'b10, 1'b0);
      step(2'b01, 1'b0);
      n_cmp++;
      if ({sell2, sold2, busy2} !== {1'b1, 2'(s + 1), 1'b0} || sold2 !== 2'(m_sold)) begin
        n_err++;
        $display("FAIL wrap sale%0d: got sell=%b cnt=%0d busy=%b want 1 %0d 0",
                 s, sell2, sold2, busy2, (s + 1) % 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    test_sequence("b2b_r0", '{2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01},
                  '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 2);
    test_sequence("b2b_fall", '{2'b10, 2'b10, 2'b00, 2'b10, 2'b01},
                  '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 3);
  endtask

  task automatic test_random();
    logic [1:0] c;
    logic       x;
    for (int i = 0; i < 400; i++) begin
      c = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 9) == 0);
      step(c, x);
      n_cmp++;
      if ({sell, change, busy, coin_rej, sold_cnt, sold2} !==
          {e_sell, e_change, e_busy, e_rej, 8'(m_sold), 2'(m_sold)}) begin
        n_err++;
        $display("FAIL random cyc%0d: got sell=%b chg=%b busy=%b rej=%b cnt=%0d/%0d want %b %b %b %b %0d",
                 i, sell, change, busy, coin_rej, sold_cnt, sold2,
                 e_sell, e_change, e_busy, e_rej, m_sold);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_reset_mid_change();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
